siso_feed_serializer: RTL and testbench
=======================================

Name: siso_feed_serializer

Overview:
Parallel-to-serial feeder that sits directly upstream of the 4-bit serial-in/serial-out shift register stage. It accepts WIDTH-bit words over a valid/ready handshake and presents them one bit at a time on a serial line, with valid and frame strobes. The downstream stage consumes a bit on every cycle where bit_en is high. A one-word holding buffer lets consecutive words stream with no gap between them.

Parameters:
WIDTH, 4, word width in bits; legal range ≥2 (matches the 4-bit downstream register by default)
MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first

Ports:
clk  input  1  clock; all logic is on the rising edge
clear_n  input  1  asynchronous active-low reset
abort  input  1  synchronous flush; discards the in-flight word and the held word
din  input  WIDTH  parallel word
din_valid  input  1  din is valid
din_ready  output  1  the word is accepted on any cycle where din_valid & din_ready
bit_en  input  1  downstream consumes the presented bit this cycle
si_out  output  1  serial data bit, drives the downstream si
si_valid  output  1  si_out carries a word bit
si_frame  output  1  high while the first bit of a word is presented
busy  output  1  si_valid | hold_v

Behaviour:
- Reset (clear_n=0, takes effect immediately, no clock needed):
  - state=IDLE, hold_v=0, sreg=0, cnt=0
  - Outputs: din_ready=1, si_valid=0, si_frame=0, si_out=0, busy=0
- Internal state:
  - hold_q[WIDTH-1:0] with flag hold_v
  - sreg[WIDTH-1:0] shift register
  - cnt, $clog2(WIDTH) bits
  - FSM with states IDLE and SHIFT
- din_ready = ~hold_v & ~abort. This is the only combinational output path.
- Accept: when din_valid & din_ready, hold_q<=din and hold_v<=1 at the clock edge.
- Output decode (all from registers):
  - si_valid = (state==SHIFT)
  - si_out = si_valid ? (MSB_FIRST ? sreg[WIDTH-1] : sreg[0]) : 0
  - si_frame = si_valid & (cnt==0)
- IDLE state:
  - If hold_v: sreg<=hold_q, cnt<=0, hold_v<=0, go to SHIFT. bit_en is not required for this load.
  - Otherwise stay in IDLE.
- SHIFT state, bit_en=0: everything holds. The presented bit stays stable until it is consumed.
- SHIFT state, bit_en=1 and cnt<WIDTH-1: shift sreg by one toward the output end (zero fill), cnt<=cnt+1.
- SHIFT state, bit_en=1 and cnt==WIDTH-1:
  - If hold_v: sreg<=hold_q, cnt<=0, hold_v<=0, stay in SHIFT. The next word's first bit follows with no gap.
  - Otherwise: go to IDLE, cnt<=0.
- Latency: word accepted at edge of cycle N → hold_v=1 in cycle N+1 → first bit presented (si_valid=1, si_frame=1) in cycle N+2.
- Throughput: with bit_en held high, one bit per cycle indefinitely. hold_v frees 1 cycle after each transfer, so a producer with valid held high never stalls the stream.
- A transfer (hold→sreg) and an accept into hold cannot happen in the same cycle, because din_ready=0 whenever hold_v=1. The new word is accepted the cycle after the transfer.
- abort=1 at a clock edge:
  - state<=IDLE, hold_v<=0, cnt<=0, sreg<=0
  - abort takes priority over accept, load and shift
  - din is not accepted in that cycle
- Reset asserted mid-word: the partial word and the held word are both lost, and there is no serial output after reset. Recovery requires a fresh din handshake.
- din_valid with no accept (din_ready=0) has no effect. The producer must keep din stable until it is accepted.

Decomposition:
- Shared package (siso_pkg):
  - state enum {IDLE, SHIFT}
  - default constant WIDTH=4
  - localparam CNT_W=$clog2(WIDTH)
- No sub-module. The holding register and the FSM/shifter live in one file. The downstream SISO instance is connected only at the top level: si←si_out, with the shift enable/clock gating qualified by bit_en.

Test Plan:
1. Reset: drive clear_n=0 asynchronously mid-word → si_valid, si_out, si_frame and busy go 0 immediately, din_ready=1; after release, no serial activity until a new din.
2. Single word: WIDTH=4, MSB_FIRST=1, bit_en=1, din=4'b1011 accepted in cycle 0 → si_valid=1 in cycles 2-5 with si_out=1,0,1,1; si_frame=1 only in cycle 2; cycle 6 back in IDLE, busy=0.
3. Back-to-back: din=4'hA then 4'h5, din_valid held high, bit_en=1 → si_out=1,0,1,0,0,1,0,1 in contiguous cycles 2-9 with si_valid never dropping; si_frame high in cycles 2 and 6.
4. Throttled consumer: bit_en=1 every other cycle, din=4'h6 → each bit held 2 cycles, sequence 0,1,1,0 presented, and cnt advances only on bit_en cycles.
5. LSB_FIRST: MSB_FIRST=0, din=4'b0001 → si_out=1,0,0,0; din_ready=0 while hold_v=1 and the producer keeps 4'h3 stable, then 4'h3 is sent intact.
6. Abort: abort=1 in cycle 3 of 4'hF with 4'h9 held and din_valid=1 → state returns to IDLE, hold is empty, din is not accepted that cycle, and si_valid=0 from cycle 4.

Source files
------------

// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared types and constants for the SISO feed serializer
package siso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam int DEFAULT_WIDTH = 4;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

endpackage

// File: rtl/siso_feed_serializer.sv
// rtl/siso_feed_serializer.sv - parallel word to serial bit feeder with one-word holding buffer
module siso_feed_serializer
    import siso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             abort,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             si_out,
    output logic             si_valid,
    output logic             si_frame,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   hold_q, hold_d;
    logic               hold_v_q, hold_v_d;
    logic [WIDTH-1:0]   sreg_q, sreg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   sreg_shifted;

    // Holding buffer can only take a word while empty, and never on an abort cycle
    assign din_ready = ~hold_v_q & ~abort;

    // Move the shift register one place toward whichever end drives the serial line
    assign sreg_shifted = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, sreg_q[WIDTH-1:1]};

    // Next-state: abort flushes everything; otherwise accept into hold and run the load/shift FSM
    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        hold_v_d = hold_v_q;
        sreg_d   = sreg_q;
        cnt_d    = cnt_q;

        if (abort) begin
            state_d  = IDLE;
            hold_v_d = 1'b0;
            cnt_d    = '0;
            sreg_d   = '0;
        end else begin
            // Accept and transfer are mutually exclusive: accept needs an empty hold,
            // transfer needs a full one.
            if (din_valid && din_ready) begin
                hold_d   = din;
                hold_v_d = 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (hold_v_q) begin
                        sreg_d   = hold_q;
                        cnt_d    = '0;
                        hold_v_d = 1'b0;
                        state_d  = SHIFT;
                    end
                end
                SHIFT: begin
                    if (bit_en) begin
                        if (cnt_q != CNT_LAST) begin
                            sreg_d = sreg_shifted;
                            cnt_d  = cnt_q + CNT_ONE;
                        end else if (hold_v_q) begin
                            // Chain straight into the next word so the stream has no gap
                            sreg_d   = hold_q;
                            cnt_d    = '0;
                            hold_v_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            cnt_d   = '0;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            hold_v_q <= 1'b0;
            sreg_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            hold_v_q <= hold_v_d;
            sreg_q   <= sreg_d;
            cnt_q    <= cnt_d;
        end
    end

    // Serial outputs decode purely from registered state
    assign si_valid = (state_q == SHIFT);
    assign si_out   = si_valid & (MSB_FIRST ? sreg_q[WIDTH-1] : sreg_q[0]);
    assign si_frame = si_valid & (cnt_q == '0);
    assign busy     = si_valid | hold_v_q;

endmodule

// File: tb/tb_siso_feed_serializer.sv
// tb/tb_siso_feed_serializer.sv - self-checking bench for siso_feed_serializer
module tb_siso_feed_serializer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         clear_n = 1'b1;
    logic         abort = 1'b0;
    logic         din_valid = 1'b0;
    logic         bit_en = 1'b0;
    logic [W-1:0] din = '0;

    logic m_ready, m_out, m_valid, m_frame, m_busy;
    logic l_ready, l_out, l_valid, l_frame, l_busy;

    int n_tests = 0;
    int n_fail  = 0;

    siso_feed_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .clear_n(clear_n), .abort(abort), .din(din), .din_valid(din_valid),
        .din_ready(m_ready), .bit_en(bit_en), .si_out(m_out), .si_valid(m_valid),
        .si_frame(m_frame), .busy(m_busy)
    );

    siso_feed_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .clear_n(clear_n), .abort(abort), .din(din), .din_valid(din_valid),
        .din_ready(l_ready), .bit_en(bit_en), .si_out(l_out), .si_valid(l_valid),
        .si_frame(l_frame), .busy(l_busy)
    );

    always #5 clk = ~clk;

    // Reference model: current word + bit index, and a one-word hold slot
    logic         m_act, m_hv;
    logic [W-1:0] m_cur, m_hold;
    int           m_idx;

    function automatic logic ebit(logic [W-1:0] w, int idx, bit msb);
        return msb ? w[W-1-idx] : w[idx];
    endfunction

    task automatic model_reset();
        m_act = 1'b0; m_hv = 1'b0; m_idx = 0; m_cur = '0; m_hold = '0;
    endtask

    task automatic model_step();
        logic acc, nh;
        if (!clear_n) begin
            model_reset();
        end else if (abort) begin
            m_act = 1'b0; m_hv = 1'b0; m_idx = 0;
        end else begin
            acc = din_valid && !m_hv;
            nh  = m_hv;
            if (!m_act) begin
                if (m_hv) begin
                    m_cur = m_hold; m_idx = 0; m_act = 1'b1; nh = 1'b0;
                end
            end else if (bit_en) begin
                if (m_idx < W - 1) m_idx++;
                else if (m_hv) begin
                    m_cur = m_hold; m_idx = 0; nh = 1'b0;
                end else begin
                    m_act = 1'b0; m_idx = 0;
                end
            end
            if (acc) begin
                m_hold = din; nh = 1'b1;
            end
            m_hv = nh;
        end
    endtask

    function automatic logic [4:0] model_exp(bit msb);
        logic b;
        b = m_act ? ebit(m_cur, m_idx, msb) : 1'b0;
        return {(!m_hv && !abort), m_act, b, (m_act && m_idx == 0), (m_act || m_hv)};
    endfunction

    task automatic check(string name, logic [4:0] act, logic [4:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (ready,valid,out,frame,busy) t=%0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_bit(string name, logic act, logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(string tag);
        check({tag, "_msb"}, {m_ready, m_valid, m_out, m_frame, m_busy}, model_exp(1'b1));
        check({tag, "_lsb"}, {l_ready, l_valid, l_out, l_frame, l_busy}, model_exp(1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    typedef struct {
        logic         dv;
        logic [W-1:0] d;
        logic         be;
        logic [4:0]   e;   // ready, valid, out, frame, busy
    } vec_t;

    vec_t tbl[18];

    task automatic set_row(int i, logic dv, logic [W-1:0] d, logic [4:0] e);
        tbl[i].dv = dv; tbl[i].d = d; tbl[i].be = 1'b1; tbl[i].e = e;
    endtask

    logic [7:0]   lsb_seq;
    logic [W-1:0] thr_word;
    logic         acc_r;

    initial begin
        model_reset();

        // Single word 4'b1011, MSB first
        set_row(0,  1'b1, 4'hB, 5'b10000);
        set_row(1,  1'b0, 4'h0, 5'b00001);
        set_row(2,  1'b0, 4'h0, 5'b11111);
        set_row(3,  1'b0, 4'h0, 5'b11001);
        set_row(4,  1'b0, 4'h0, 5'b11101);
        set_row(5,  1'b0, 4'h0, 5'b11101);
        set_row(6,  1'b0, 4'h0, 5'b10000);
        // Back-to-back 4'hA then 4'h5
        set_row(7,  1'b1, 4'hA, 5'b10000);
        set_row(8,  1'b1, 4'h5, 5'b00001);
        set_row(9,  1'b1, 4'h5, 5'b11111);
        set_row(10, 1'b0, 4'h0, 5'b01001);
        set_row(11, 1'b0, 4'h0, 5'b01101);
        set_row(12, 1'b0, 4'h0, 5'b01001);
        set_row(13, 1'b0, 4'h0, 5'b11011);
        set_row(14, 1'b0, 4'h0, 5'b11101);
        set_row(15, 1'b0, 4'h0, 5'b11001);
        set_row(16, 1'b0, 4'h0, 5'b11101);
        set_row(17, 1'b0, 4'h0, 5'b10000);

        // Reset state
        #2 clear_n = 1'b0;
        #1 check("reset_msb", {m_ready, m_valid, m_out, m_frame, m_busy}, 5'b10000);
        check("reset_lsb", {l_ready, l_valid, l_out, l_frame, l_busy}, 5'b10000);
        @(negedge clk);
        clear_n = 1'b1;
        bit_en  = 1'b1;

        // Asynchronous reset mid-word with a second word held
        din_valid = 1'b1; din = 4'hB; tick();
        din = 4'h7; tick();
        tick();
        #2 clear_n = 1'b0;
        #1 check("midreset_msb", {m_ready, m_valid, m_out, m_frame, m_busy}, 5'b10000);
        check("midreset_lsb", {l_ready, l_valid, l_out, l_frame, l_busy}, 5'b10000);
        model_reset();
        din_valid = 1'b0;
        @(negedge clk);
        clear_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1 check_bit($sformatf("post_reset_quiet_%0d", c), m_valid | m_busy, 1'b0);
            check_model("post_reset");
            tick();
        end

        // Table-driven single-word and back-to-back streams
        for (int i = 0; i < 18; i++) begin
            din_valid = tbl[i].dv; din = tbl[i].d; bit_en = tbl[i].be; abort = 1'b0;
            #1 check($sformatf("table_row_%0d", i),
                     {m_ready, m_valid, m_out, m_frame, m_busy}, tbl[i].e);
            tick();
        end

        // Throttled consumer: bit_en every other cycle, word 4'h6
        thr_word = 4'h6;
        din_valid = 1'b1; din = thr_word; bit_en = 1'b0; tick();
        din_valid = 1'b0; tick();
        for (int c = 2; c < 10; c++) begin
            bit_en = c[0];
            #1 check($sformatf("throttle_c%0d", c), {m_valid, m_out, m_frame},
                     {1'b1, thr_word[W-1-((c-2)/2)], 1'b0} | {2'b00, (c < 4)});
            tick();
        end
        #1 check_bit("throttle_done", m_valid | m_busy, 1'b0);

        // LSB first 4'b0001, then 4'h3 held stable while blocked
        bit_en = 1'b1;
        lsb_seq = 8'b0011_0001;
        din_valid = 1'b1; din = 4'h1; tick();
        din = 4'h3;
        #1 check_bit("lsb_blocked_ready", l_ready, 1'b0);
        check_model("lsb_c1");
        tick();
        for (int c = 2; c < 11; c++) begin
            if (c > 2) din_valid = 1'b0;
            #1 if (c < 10) check_bit($sformatf("lsb_bit_c%0d", c), l_out, lsb_seq[c-2]);
            else check_bit("lsb_done", l_valid, 1'b0);
            check_model($sformatf("lsb_c%0d", c));
            tick();
        end

        // Abort with a word in flight and another held
        din_valid = 1'b1; din = 4'hF; tick();
        din = 4'h9; tick();
        tick();
        din = 4'h3; abort = 1'b1;
        #1 check_bit("abort_ready_low", m_ready, 1'b0);
        check_bit("abort_busy_before", m_busy, 1'b1);
        tick();
        abort = 1'b0; din_valid = 1'b0;
        for (int c = 4; c < 7; c++) begin
            #1 check($sformatf("abort_after_c%0d", c),
                     {m_ready, m_valid, m_out, m_frame, m_busy}, 5'b10000);
            check_model($sformatf("abort_c%0d", c));
            tick();
        end

        // Randomized traffic against the reference model
        din_valid = 1'b0;
        for (int c = 0; c < 4000; c++) begin
            if (!din_valid) begin
                din_valid = ($urandom_range(0, 99) < 60);
                din       = W'($urandom);
            end
            bit_en = ($urandom_range(0, 99) < 70);
            abort  = ($urandom_range(0, 99) < 3);
            #1 check_model("random");
            acc_r = din_valid && !m_hv && !abort;
            tick();
            if (acc_r) din_valid = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
